// File: rtl/tug_pkg.sv
// Shared types and rope-position constants for the tug-of-war round controller.
package tug_pkg;

  typedef enum logic {PLAY, HOLD} state_t;

  localparam int POS_W = 4;
  localparam logic [POS_W-1:0] POS_CENTER = 4'd4;
  localparam logic [POS_W-1:0] POS_MIN    = 4'd0;
  localparam logic [POS_W-1:0] POS_MAX    = 4'd8;

endpackage

// File: rtl/tug_round_controller_pace_tick.sv
// Free-running modulo-DIV counter; tick is high for the single cycle in which count == DIV-1.
module pace_tick #(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // Compare against DIV-2 so the registered tick lines up with count == DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == W'(DIV - 1)) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
      tick <= (cnt == W'(DIV - 2));
    end
  end

endmodule

// File: rtl/tug_round_controller.sv
// Round sequencer and press arbiter: paces computer presses, resolves collisions,
// moves the rope light, detects wins and keeps saturating per-player scores.
module tug_round_controller
  import tug_pkg::*;
#(
  parameter int PACE_DIV       = 1024,
  parameter int RESTART_CYCLES = 256,
  parameter int SCORE_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               human_key,
  input  logic               comp_req,
  output logic [8:0]         led_pos,
  output logic               comp_press,
  output logic               round_over,
  output logic               winner,
  output logic [SCORE_W-1:0] score_h,
  output logic [SCORE_W-1:0] score_c
);

  localparam int HOLD_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESTART_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};

  state_t            state;
  logic [POS_W-1:0]  pos;
  logic [HOLD_W-1:0] hold_cnt;
  logic              key_q;
  logic              tick;
  logic              hp;
  logic              cp;

  pace_tick #(.DIV(PACE_DIV)) u_pace (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign hp = human_key & ~key_q;
  assign cp = tick & comp_req;

  assign led_pos    = 9'b1 << pos;
  assign round_over = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      pos        <= POS_CENTER;
      hold_cnt   <= '0;
      key_q      <= 1'b0;
      comp_press <= 1'b0;
      winner     <= 1'b0;
      score_h    <= '0;
      score_c    <= '0;
    end else begin
      key_q      <= human_key;
      comp_press <= 1'b0;
      case (state)
        PLAY: begin
          // Simultaneous presses cancel: neither side moves the rope.
          if (hp && cp) begin
            pos <= pos;
          end else if (hp) begin
            if (pos == POS_MIN) begin
              winner <= 1'b0;
              if (score_h != SCORE_SAT) score_h <= score_h + 1'b1;
              state  <= HOLD;
            end else begin
              pos <= pos - 1'b1;
            end
          end else if (cp) begin
            comp_press <= 1'b1;
            if (pos == POS_MAX) begin
              winner <= 1'b1;
              if (score_c != SCORE_SAT) score_c <= score_c + 1'b1;
              state  <= HOLD;
            end else begin
              pos <= pos + 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= PLAY;
            pos      <= POS_CENTER;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_tug_round_controller.sv
// Scoreboarded bench: a cycle model predicts outputs at each edge, checked half a cycle later.
module tb_tug_round_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       human_key;
  logic       comp_req;
  logic [8:0] led_pos;
  logic       comp_press;
  logic       round_over;
  logic       winner;
  logic [2:0] score_h;
  logic [2:0] score_c;

  int checks = 0;
  int errors = 0;
  int cp_seen = 0;
  int ro_seen = 0;

  always #5 clk = ~clk;

  tug_round_controller #(
    .PACE_DIV      (4),
    .RESTART_CYCLES(3),
    .SCORE_W       (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .human_key (human_key),
    .comp_req  (comp_req),
    .led_pos   (led_pos),
    .comp_press(comp_press),
    .round_over(round_over),
    .winner    (winner),
    .score_h   (score_h),
    .score_c   (score_c)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [17:0] exp_q[$];
  bit          m_valid = 0;
  int          m_pos, m_cyc, m_hold_left, m_sh, m_sc;
  bit          m_hold, m_key_q, m_win, m_cp;

  always @(posedge clk) begin
    bit tk, hpress;
    if (reset) begin
      m_valid = 1; m_pos = 4; m_cyc = 0; m_hold = 0; m_hold_left = 0;
      m_key_q = 0; m_win = 0; m_sh = 0; m_sc = 0; m_cp = 0;
    end else if (m_valid) begin
      tk     = (m_cyc == 3);
      m_cyc  = (m_cyc + 1) % 4;
      hpress = human_key && !m_key_q;
      m_key_q = human_key;
      m_cp   = 0;
      if (!m_hold) begin
        if (hpress && tk && comp_req) begin
          m_cp = 0;
        end else if (hpress) begin
          if (m_pos == 0) begin
            m_win = 0; m_sh = (m_sh < 7) ? m_sh + 1 : 7;
            m_hold = 1; m_hold_left = 3;
          end else m_pos = m_pos - 1;
        end else if (tk && comp_req) begin
          m_cp = 1;
          if (m_pos == 8) begin
            m_win = 1; m_sc = (m_sc < 7) ? m_sc + 1 : 7;
            m_hold = 1; m_hold_left = 3;
          end else m_pos = m_pos + 1;
        end
      end else begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) begin
          m_hold = 0; m_pos = 4;
        end
      end
    end
    if (m_valid) begin
      logic [8:0] onehot;
      onehot = 9'd1 << m_pos;
      exp_q.push_back({onehot, m_cp, m_hold, m_win, 3'(m_sh), 3'(m_sc)});
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      check_val("cycle_outputs",
                {14'd0, led_pos, comp_press, round_over, winner, score_h, score_c}, {14'd0, e});
      if (comp_press === 1'b1) cp_seen++;
      if (round_over === 1'b1) ro_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    human_key = 1'b1;
    @(negedge clk);
    human_key = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; human_key = 1'b0; comp_req = 1'b0;

    // 1: reset then idle
    cycles(2);
    reset = 1'b0;
    cycles(20);
    check_val("idle_led", 32'(led_pos), 32'h010);
    check_val("idle_score_h", 32'(score_h), 0);
    check_val("idle_score_c", 32'(score_c), 0);
    check_val("idle_no_comp_press", cp_seen, 0);

    // 2: long key hold gives one step
    human_key = 1'b1;
    @(negedge clk);
    check_val("key_step", 32'(led_pos), 32'h008);
    cycles(9);
    human_key = 1'b0;
    cycles(1);
    check_val("key_hold_single", 32'(led_pos), 32'h008);

    // 3: computer walks to the right end and wins
    do_reset();
    comp_req = 1'b1;
    cp_seen = 0; ro_seen = 0;
    cycles(22);
    comp_req = 1'b0;
    cycles(6);
    check_val("comp_pulses", cp_seen, 5);
    check_val("hold_len", ro_seen, 3);
    check_val("comp_winner", 32'(winner), 1);
    check_val("comp_score", 32'(score_c), 1);
    check_val("comp_recentre", 32'(led_pos), 32'h010);

    // 4: key edge coincides with a tick
    do_reset();
    comp_req = 1'b1;
    cycles(3);
    human_key = 1'b1;
    @(negedge clk);
    check_val("cancel_pos", 32'(led_pos), 32'h010);
    check_val("cancel_comp_press", 32'(comp_press), 0);
    comp_req = 1'b0;
    human_key = 1'b0;
    cycles(2);

    // 5: human wins; key edge during hold is ignored
    repeat (5) press();
    check_val("human_hold", 32'(round_over), 1);
    press();
    cycles(3);
    check_val("human_recentre", 32'(led_pos), 32'h010);
    check_val("human_winner", 32'(winner), 0);
    check_val("human_score", 32'(score_h), 1);
    check_val("human_play", 32'(round_over), 0);

    // 6: saturation, then reset in the middle of hold
    repeat (7) begin
      repeat (5) press();
      cycles(3);
    end
    repeat (5) press();
    check_val("sat_score_h", 32'(score_h), 7);
    check_val("sat_hold", 32'(round_over), 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_round_over", 32'(round_over), 0);
    check_val("rst_score_h", 32'(score_h), 0);
    check_val("rst_led", 32'(led_pos), 32'h010);
    reset = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
